// File: rtl/vote_pkg.sv
// Shared defaults, field widths, FSM state type and tally helper for the
// ballot-collection session block.
package vote_pkg;

  localparam int N_VOTERS_DEF  = 7;
  localparam int THRESHOLD_DEF = 4;
  localparam int TIMEOUT_DEF   = 255;

  localparam int IDX_W = 3;
  localparam int YES_W = 4;
  localparam int TO_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DONE    = 2'd2
  } state_t;

  // Saturating increment: the tally can never pass the number of voters,
  // so a stray extra ballot can never wrap the count.
  function automatic logic [YES_W-1:0] sat_add(
    input logic [YES_W-1:0] a,
    input logic             inc,
    input logic [YES_W-1:0] lim
  );
    if (inc && (a < lim)) begin
      return a + YES_W'(1);
    end
    return a;
  endfunction

endpackage

// File: rtl/vote_timer.sv
// Per-ballot wait timer. Counts enabled cycles since the last load and
// flags expiry on the TIMEOUT-th enabled cycle.
module vote_timer #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expire
);

  // Count only ever reaches TIMEOUT-1 before being reloaded or wrapped.
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  logic [CW-1:0] r_count;
  logic          w_terminal;

  assign w_terminal = (r_count == CW'(TIMEOUT - 1));

  // Expiry is only meaningful while the owner is actively waiting, so a
  // ballot arriving on the terminal cycle (enable low) suppresses it.
  assign expire = enable && w_terminal;

  // Load clears the count; enable advances it and wraps on the terminal value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (load) begin
      r_count <= '0;
    end else if (enable) begin
      r_count <= w_terminal ? '0 : r_count + CW'(1);
    end
  end

endmodule

// File: rtl/vote_session.sv
// Ballot session controller: opens a session on start, collects one ballot
// per voter (defaulting to "no" on timeout), and publishes a one-cycle
// result with held yes-count, pass flag and timeout count.
module vote_session
  import vote_pkg::*;
#(
  parameter int N_VOTERS  = N_VOTERS_DEF,
  parameter int THRESHOLD = THRESHOLD_DEF,
  parameter int TIMEOUT   = TIMEOUT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             vote_valid,
  input  logic             vote_bit,
  output logic             vote_ready,
  output logic [IDX_W-1:0] voter_idx,
  output logic             busy,
  output logic             result_valid,
  output logic             pass,
  output logic [YES_W-1:0] yes_count,
  output logic [TO_W-1:0]  timeouts
);

  state_t           r_state;
  state_t           w_state_next;

  logic [YES_W-1:0] r_tally;
  logic [IDX_W-1:0] r_idx;
  logic [TO_W-1:0]  r_to_cnt;
  logic [YES_W-1:0] r_yes;
  logic             r_pass;
  logic [TO_W-1:0]  r_timeouts;
  logic             r_result_valid;
  logic             r_vote_ready;

  logic [YES_W-1:0] w_tally_next;
  logic [IDX_W-1:0] w_idx_next;
  logic [TO_W-1:0]  w_to_cnt_next;
  logic [YES_W-1:0] w_yes_next;
  logic             w_pass_next;
  logic [TO_W-1:0]  w_timeouts_next;
  logic             w_result_valid_next;

  logic             w_accept;
  logic             w_expire;
  logic             w_timeout;
  logic             w_load;
  logic             w_enable;
  logic             w_last;
  logic [YES_W-1:0] w_tally_upd;
  logic [TO_W-1:0]  w_to_upd;
  logic             w_pass_calc;

  // A ballot is taken only while ready, which is registered high exactly in COLLECT.
  assign w_accept = r_vote_ready && vote_valid;

  // The timer runs on cycles spent waiting; an accepted ballot stops it
  // for that cycle so a same-cycle ballot always beats expiry.
  assign w_enable = (r_state == COLLECT) && !w_accept;

  // Abort outranks a pending timeout.
  assign w_timeout = w_expire && !abort;

  assign w_last      = (r_idx == IDX_W'(N_VOTERS - 1));
  assign w_tally_upd = sat_add(r_tally, w_accept && vote_bit, YES_W'(N_VOTERS));
  assign w_to_upd    = r_to_cnt + {{(TO_W-1){1'b0}}, w_timeout};
  assign w_pass_calc = (int'(w_tally_upd) >= THRESHOLD);

  vote_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   (w_load),
    .enable (w_enable),
    .expire (w_expire)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state and datapath updates; every ballot resolution reloads the timer.
  always_comb begin
    w_state_next        = r_state;
    w_tally_next        = r_tally;
    w_idx_next          = r_idx;
    w_to_cnt_next       = r_to_cnt;
    w_yes_next          = r_yes;
    w_pass_next         = r_pass;
    w_timeouts_next     = r_timeouts;
    w_result_valid_next = 1'b0;
    w_load              = 1'b0;

    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_next    = COLLECT;
          w_tally_next    = '0;
          w_idx_next      = '0;
          w_to_cnt_next   = '0;
          w_yes_next      = '0;
          w_pass_next     = 1'b0;
          w_timeouts_next = '0;
          w_load          = 1'b1;
        end
      end

      COLLECT: begin
        if (abort) begin
          // Session discarded; held result fields keep their cleared values.
          w_state_next = IDLE;
          w_idx_next   = '0;
          w_load       = 1'b1;
        end else if (w_accept || w_timeout) begin
          w_tally_next  = w_tally_upd;
          w_to_cnt_next = w_to_upd;
          w_load        = 1'b1;
          if (w_last) begin
            w_state_next        = DONE;
            w_idx_next          = '0;
            w_yes_next          = w_tally_upd;
            w_pass_next         = w_pass_calc;
            w_timeouts_next     = w_to_upd;
            w_result_valid_next = 1'b1;
          end else begin
            w_idx_next = r_idx + IDX_W'(1);
          end
        end
      end

      DONE: begin
        w_state_next = IDLE;
      end

      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Session counters and held result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tally        <= '0;
      r_idx          <= '0;
      r_to_cnt       <= '0;
      r_yes          <= '0;
      r_pass         <= 1'b0;
      r_timeouts     <= '0;
      r_result_valid <= 1'b0;
      r_vote_ready   <= 1'b0;
    end else begin
      r_tally        <= w_tally_next;
      r_idx          <= w_idx_next;
      r_to_cnt       <= w_to_cnt_next;
      r_yes          <= w_yes_next;
      r_pass         <= w_pass_next;
      r_timeouts     <= w_timeouts_next;
      r_result_valid <= w_result_valid_next;
      r_vote_ready   <= (w_state_next == COLLECT);
    end
  end

  assign busy         = (r_state == COLLECT);
  assign vote_ready   = r_vote_ready;
  assign voter_idx    = r_idx;
  assign result_valid = r_result_valid;
  assign pass         = r_pass;
  assign yes_count    = r_yes;
  assign timeouts     = r_timeouts;

endmodule

// File: tb/tb_vote_session.sv
// Directed bench for vote_session: stimulus pushes expected session results
// into a queue; a negedge monitor pops and checks them on every result pulse.
module tb_vote_session;

  localparam int T = 255;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic       vote_valid;
  logic       vote_bit;
  logic       vote_ready;
  logic [2:0] voter_idx;
  logic       busy;
  logic       result_valid;
  logic       pass;
  logic [3:0] yes_count;
  logic [2:0] timeouts;

  typedef struct {
    int yes;
    int pass;
    int to;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   tests = 0;
  int   fails = 0;
  logic prev_rv = 1'b0;

  vote_session dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .abort        (abort),
    .vote_valid   (vote_valid),
    .vote_bit     (vote_bit),
    .vote_ready   (vote_ready),
    .voter_idx    (voter_idx),
    .busy         (busy),
    .result_valid (result_valid),
    .pass         (pass),
    .yes_count    (yes_count),
    .timeouts     (timeouts)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0d", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ballot(input int b);
    vote_valid = 1'b1;
    vote_bit   = b[0];
    tick();
    vote_valid = 1'b0;
    vote_bit   = 1'b0;
  endtask

  task automatic open_session();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ready"}, int'(vote_ready), 0);
    chk({tag, "_idx"}, int'(voter_idx), 0);
    chk({tag, "_rv"}, int'(result_valid), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_yes"}, int'(yes_count), 0);
    chk({tag, "_to"}, int'(timeouts), 0);
  endtask

  // Scoreboard monitor: each result pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (result_valid === 1'b1) begin
      chk("rv_pulse_width", int'(prev_rv), 0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_result: got result_valid 1, expected none");
      end else begin
        mon_e = sb.pop_front();
        chk("sb_yes_count", int'(yes_count), mon_e.yes);
        chk("sb_pass", int'(pass), mon_e.pass);
        chk("sb_timeouts", int'(timeouts), mon_e.to);
      end
    end
    prev_rv = (result_valid === 1'b1);
  end

  initial begin
    int b036[7];
    int b038[5];
    b036 = '{1, 1, 0, 1, 1, 0, 0};
    b038 = '{1, 1, 1, 0, 0};

    rst_n      = 1'b1;
    start      = 1'b0;
    abort      = 1'b0;
    vote_valid = 1'b0;
    vote_bit   = 1'b0;
    #3 rst_n = 1'b0;
    repeat (3) tick();
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Back-to-back ballots 1,1,0,1,1,0,0.
    sb.push_back('{4, 1, 0});
    open_session();
    chk("t036_busy", int'(busy), 1);
    chk("t036_ready", int'(vote_ready), 1);
    for (int i = 0; i < 7; i++) begin
      chk("t036_idx", int'(voter_idx), i);
      ballot(b036[i]);
    end
    chk("t036_latency_rv", int'(result_valid), 1);
    chk("t036_done_idx", int'(voter_idx), 0);
    chk("t036_done_busy", int'(busy), 0);
    chk("t036_done_ready", int'(vote_ready), 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("t036_start_in_done_busy", int'(busy), 0);
    chk("t036_rv_dropped", int'(result_valid), 0);
    tick();
    chk("t036_held_yes", int'(yes_count), 4);
    chk("t036_held_pass", int'(pass), 1);

    // Three yes ballots then four full timeouts.
    sb.push_back('{3, 0, 4});
    open_session();
    chk("t037_start_clears_yes", int'(yes_count), 0);
    chk("t037_start_clears_pass", int'(pass), 0);
    for (int i = 0; i < 3; i++) ballot(1);
    for (int k = 1; k <= 4; k++) begin
      repeat (T - 1) tick();
      chk("t037_idx_before_expiry", int'(voter_idx), 2 + k);
      tick();
      if (k < 4) chk("t037_idx_after_expiry", int'(voter_idx), 3 + k);
    end
    chk("t037_latency_rv", int'(result_valid), 1);
    tick();

    // Ballot on the exact expiry cycle of voter 2 counts as a real yes.
    sb.push_back('{4, 1, 0});
    open_session();
    ballot(1);
    ballot(0);
    repeat (T - 1) tick();
    chk("t038_idx_at_expiry", int'(voter_idx), 2);
    ballot(1);
    chk("t038_idx_after", int'(voter_idx), 3);
    for (int i = 0; i < 4; i++) ballot(b038[i + 1]);
    chk("t038_latency_rv", int'(result_valid), 1);
    tick();

    // Abort with a concurrent ballot, then a full yes session.
    open_session();
    for (int i = 0; i < 3; i++) ballot(1);
    abort      = 1'b1;
    vote_valid = 1'b1;
    vote_bit   = 1'b1;
    tick();
    abort      = 1'b0;
    vote_valid = 1'b0;
    vote_bit   = 1'b0;
    chk_all_zero("t039_abort");
    repeat (3) tick();
    chk("t039_no_result", int'(result_valid), 0);
    sb.push_back('{7, 1, 0});
    start = 1'b1;
    abort = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    chk("t039_abort_idle_ignored_busy", int'(busy), 1);
    for (int i = 0; i < 7; i++) ballot(1);
    chk("t039_latency_rv", int'(result_valid), 1);
    tick();

    // Start while busy is ignored; reset mid-session discards everything.
    open_session();
    for (int i = 0; i < 5; i++) begin
      if (i == 2) start = 1'b1;
      ballot(1);
      start = 1'b0;
      if (i == 2) chk("t040_start_busy_idx", int'(voter_idx), 3);
    end
    chk("t040_idx_before_reset", int'(voter_idx), 5);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t040_async_reset");
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (3) tick();
    chk_all_zero("t040_after_release");

    // Ballots offered in IDLE must not leak into the next session.
    vote_valid = 1'b1;
    vote_bit   = 1'b1;
    repeat (3) tick();
    vote_valid = 1'b0;
    vote_bit   = 1'b0;
    chk("t028_idle_busy", int'(busy), 0);
    sb.push_back('{0, 0, 0});
    open_session();
    for (int i = 0; i < 7; i++) ballot(0);
    chk("t028_latency_rv", int'(result_valid), 1);

    repeat (3) tick();
    chk("sb_pending_results", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/vote_session.md
VOTE_SESSION -- requirements
Module: vote_session

Interface
REQ-001 Parameter N_VOTERS, default 7: number of ballots collected per session.
REQ-002 Parameter THRESHOLD, default 4: minimum yes-count for pass.
REQ-003 Parameter TIMEOUT, default 255: cycles allowed per ballot before it is recorded as no.
REQ-004 The block SHALL use one clock; reset is asynchronous and active-low, ports clk and rst_n.
REQ-005 clk  in  1  rising-edge system clock.
REQ-006 rst_n  in  1  asynchronous active-low reset.
REQ-007 start  in  1  single-cycle request to open a session.
REQ-008 abort  in  1  cancel the open session, no result.
REQ-009 vote_valid  in  1  ballot present on vote_bit.
REQ-010 vote_bit  in  1  ballot value, 1 = yes.
REQ-011 vote_ready  out  1  block accepts a ballot this cycle.
REQ-012 voter_idx  out  3  index of the ballot expected next, 0..N_VOTERS-1.
REQ-013 busy  out  1  session open.
REQ-014 result_valid  out  1  one-cycle pulse, result fields valid.
REQ-015 pass  out  1  yes_count >= THRESHOLD, held until next session start.
REQ-016 yes_count  out  4  yes ballots in last session, held.
REQ-017 timeouts  out  3  ballots defaulted by timeout in last session, held.

Function
REQ-018 FSM states SHALL be IDLE, COLLECT, DONE.
REQ-019 IDLE -> COLLECT on start; tally, voter_idx, timeout count and timer clear in that transition; pass, yes_count, timeouts clear at the same edge.
REQ-020 vote_ready SHALL be high only in COLLECT; a ballot is accepted on a cycle with vote_valid and vote_ready both high.
REQ-021 Each accepted ballot SHALL add vote_bit to the tally, increment voter_idx, and reload the timer.
REQ-022 Timer SHALL count cycles in COLLECT without an accepted ballot; on reaching TIMEOUT the current ballot SHALL be recorded as no, timeouts incremented, voter_idx advanced, timer reloaded.
REQ-023 A ballot accepted in the same cycle the timer expires SHALL be counted as a real ballot; no timeout is recorded.
REQ-024 After the ballot at voter_idx = N_VOTERS-1 is resolved, next state SHALL be DONE; result_valid pulses high for exactly the one DONE cycle, then the FSM returns to IDLE.
REQ-025 Result latency: result_valid SHALL be high in the cycle immediately after the final ballot is resolved.
REQ-026 yes_count width 4 bits; tally SHALL never exceed N_VOTERS, no wrap.
REQ-027 start while busy or in DONE SHALL be ignored.
REQ-028 vote_valid outside COLLECT SHALL be ignored and not affect the tally.
REQ-029 abort in COLLECT SHALL return to IDLE next cycle, no result_valid, held outputs keep cleared values; abort has priority over a simultaneous ballot or timeout; abort in IDLE or DONE ignored.
REQ-030 voter_idx SHALL read 0 in IDLE and DONE.

Reset
REQ-031 On rst_n low, asynchronously: state IDLE, busy 0, vote_ready 0, voter_idx 0, result_valid 0, pass 0, yes_count 0, timeouts 0, timer 0.
REQ-032 Reset asserted mid-session SHALL discard the session; no result_valid after release.

Structure
REQ-033 Package vote_pkg SHALL hold N_VOTERS, THRESHOLD, TIMEOUT defaults and the FSM state type.
REQ-034 Ballot timer SHALL be one sub-module, vote_timer (load, enable, expire).
REQ-035 busy SHALL equal state COLLECT; all other outputs registered.

Verification
REQ-036 start, ballots 1,1,0,1,1,0,0 back-to-back -> result_valid one cycle after 7th, yes_count 4, pass 1, timeouts 0.
REQ-037 start, ballots 1,1,1 then no vote_valid for 4*TIMEOUT cycles -> yes_count 3, timeouts 4, pass 0.
REQ-038 vote_valid=1, vote_bit=1 on exact expiry cycle of voter 2 -> counted yes, timeouts unchanged.
REQ-039 abort after 3 ballots, concurrent vote_valid -> IDLE, no result_valid, yes_count 0; new start then 7 yes -> yes_count 7, pass 1.
REQ-040 rst_n low after 5 ballots, then release -> all outputs 0, no result_valid; start during busy ignored, voter_idx unaffected.
